// File: rtl/switch_allocator.sv
// switch_allocator
//
// Per-outport round-robin switch allocator. Each outport picks one requesting
// input buffer and reserves itself until that buffer reports that its packet
// has drained. For each outport the allocator holds a busy bit, the owning
// buffer index and a round-robin pointer. All outports arbitrate independently
// and in parallel.
//
// Ports
//   CLK             switch clock. All state changes on its rising edge.
//   nRST            asynchronous active-low reset.
//   req_switch      [NUM_BUFFERS]        buffer i requests an outport.
//   switch_outport  [NUM_BUFFERS][OPW]   outport requested by buffer i.
//   pkt_done        [NUM_BUFFERS]        buffer i read its tail flit (pulse).
//   switch_granted  [NUM_BUFFERS]        registered one-cycle grant pulse.
//   outport_busy    [NUM_OUTPORTS]       outport reserved. Also the crossbar enable.
//   xbar_sel        [NUM_OUTPORTS][SELW] owning buffer index. 0 while idle.

module switch_allocator #(
    parameter  int NUM_BUFFERS  = 4,
    parameter  int NUM_OUTPORTS = 4,
    localparam int SELW         = $clog2(NUM_BUFFERS),
    localparam int OPW          = $clog2(NUM_OUTPORTS)
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic [NUM_BUFFERS-1:0]                  req_switch,
    input  logic [NUM_BUFFERS-1:0][OPW-1:0]         switch_outport,
    input  logic [NUM_BUFFERS-1:0]                  pkt_done,
    output logic [NUM_BUFFERS-1:0]                  switch_granted,
    output logic [NUM_OUTPORTS-1:0]                 outport_busy,
    output logic [NUM_OUTPORTS-1:0][SELW-1:0]       xbar_sel
);

    logic [NUM_OUTPORTS-1:0]                  busy;
    logic [NUM_OUTPORTS-1:0][SELW-1:0]        owner;
    logic [NUM_OUTPORTS-1:0][SELW-1:0]        rr_ptr;

    logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] cand;
    logic [NUM_OUTPORTS-1:0]                  owner_done;
    logic [NUM_OUTPORTS-1:0]                  port_free;
    logic [NUM_OUTPORTS-1:0]                  win_vld;
    logic [NUM_OUTPORTS-1:0][SELW-1:0]        win_idx;
    logic [NUM_OUTPORTS-1:0][SELW-1:0]        rr_nxt;
    logic [NUM_BUFFERS-1:0]                   grant_nxt;
    int                                       idx;

    always_comb begin
        cand       = '0;
        owner_done = '0;
        port_free  = '0;
        win_vld    = '0;
        win_idx    = '0;
        rr_nxt     = '0;
        grant_nxt  = '0;
        idx        = 0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                // A buffer still shows its request during its grant-pulse cycle,
                // so it is masked out for that one cycle.
                cand[o][i] = req_switch[i] && (switch_outport[i] == OPW'(o))
                             && !switch_granted[i];
                // pkt_done only counts when it comes from the current owner.
                if (busy[o] && (owner[o] == SELW'(i)) && pkt_done[i])
                    owner_done[o] = 1'b1;
            end
            port_free[o] = !busy[o] || owner_done[o];

            // Scan from rr_ptr with an explicit wrap, so a buffer count that
            // is not a power of two never produces an out-of-range index.
            for (int k = 0; k < NUM_BUFFERS; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NUM_BUFFERS)
                    idx = idx - NUM_BUFFERS;
                if (!win_vld[o] && cand[o][idx]) begin
                    win_vld[o] = 1'b1;
                    win_idx[o] = SELW'(idx);
                end
            end

            if (win_idx[o] == SELW'(NUM_BUFFERS - 1))
                rr_nxt[o] = '0;
            else
                rr_nxt[o] = win_idx[o] + SELW'(1);

            if (port_free[o] && win_vld[o])
                grant_nxt[win_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy           <= '0;
            owner          <= '0;
            rr_ptr         <= '0;
            switch_granted <= '0;
        end else begin
            switch_granted <= grant_nxt;
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                if (port_free[o]) begin
                    if (win_vld[o]) begin
                        busy[o]   <= 1'b1;
                        owner[o]  <= win_idx[o];
                        rr_ptr[o] <= rr_nxt[o];
                    end else begin
                        busy[o]   <= 1'b0;
                        owner[o]  <= '0;
                    end
                end
            end
        end
    end

    assign outport_busy = busy;
    assign xbar_sel     = owner;

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

    logic             CLK = 1'b0;
    logic             nRST;

    // Default-sized instance: 4 buffers, 4 outports.
    logic [3:0]       req4, done4, g4, b4;
    logic [3:0][1:0]  outp4, s4o;

    // Non-power-of-2 instance: 3 buffers, 2 outports.
    logic [2:0]       req3, done3, g3;
    logic [2:0][0:0]  outp3;
    logic [1:0]       b3;
    logic [1:0][1:0]  s3o;

    typedef struct {
        string      tag;
        bit         which;
        logic [3:0] g;
        logic [3:0] b;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 CLK = ~CLK;

    switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_switch(req4), .switch_outport(outp4), .pkt_done(done4),
        .switch_granted(g4), .outport_busy(b4), .xbar_sel(s4o)
    );

    switch_allocator #(.NUM_BUFFERS(3), .NUM_OUTPORTS(2)) dut3 (
        .CLK(CLK), .nRST(nRST),
        .req_switch(req3), .switch_outport(outp3), .pkt_done(done3),
        .switch_granted(g3), .outport_busy(b3), .xbar_sel(s3o)
    );

    function automatic logic [7:0] s4(input int o, input int v);
        logic [7:0] r;
        r = '0;
        r[o*2 +: 2] = v[1:0];
        return r;
    endfunction

    task automatic push4(input string tag, input logic [3:0] g, input logic [3:0] b,
                         input logic [7:0] s);
        exp_t e;
        e.tag = tag; e.which = 1'b0; e.g = g; e.b = b; e.s = s;
        sb.push_back(e);
    endtask

    task automatic push3(input string tag, input logic [2:0] g, input logic [1:0] b,
                         input logic [3:0] s);
        exp_t e;
        e.tag = tag; e.which = 1'b1; e.g = {1'b0, g}; e.b = {2'b00, b}; e.s = {4'b0, s};
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.which == 1'b0)
                obs = {g4, b4, s4o};
            else
                obs = {1'b0, g3, 2'b00, b3, 4'b0000, s3o};
            n_checks++;
            assert (obs === {e.g, e.b, e.s}) n_pass++;
            else $error("FAIL %s: observed gnt=%b busy=%b sel=%h expected gnt=%b busy=%b sel=%h",
                        e.tag, obs[15:12], obs[11:8], obs[7:0], e.g, e.b, e.s);
        end
    endtask

    // Inputs are set before calling; expectation applies after the next edge.
    task automatic step(input string tag, input logic [3:0] g, input logic [3:0] b,
                        input logic [7:0] s);
        push4(tag, g, b, s);
        @(posedge CLK); #1;
        check_now();
        @(negedge CLK);
    endtask

    task automatic step3(input string tag, input logic [2:0] g, input logic [1:0] b,
                         input logic [3:0] s);
        push3(tag, g, b, s);
        @(posedge CLK); #1;
        check_now();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        req4 = '0; done4 = '0; outp4 = '0;
        req3 = '0; done3 = '0; outp3 = '0;
        @(negedge CLK);

        // Reset held with random inputs.
        for (int c = 0; c < 3; c++) begin
            req4 = 4'($urandom); done4 = 4'($urandom); outp4 = 8'($urandom);
            req3 = 3'($urandom); done3 = 3'($urandom); outp3 = 3'($urandom);
            push3("rst_hold3", 3'b0, 2'b0, 4'h0);
            step("rst_hold", 4'b0, 4'b0, 8'h0);
        end
        req4 = '0; done4 = '0; outp4 = '0;
        req3 = '0; done3 = '0; outp3 = '0;
        nRST = 1'b1;
        step("idle_0", 4'b0, 4'b0, 8'h0);
        step("idle_1", 4'b0, 4'b0, 8'h0);

        // Single grant and release.
        req4 = 4'b0100; outp4[2] = 2'd1;
        step("single_g", 4'b0100, 4'b0010, s4(1, 2));
        req4 = '0;
        step("single_h0", 4'b0000, 4'b0010, s4(1, 2));
        step("single_h1", 4'b0000, 4'b0010, s4(1, 2));
        done4 = 4'b0100;
        step("single_rel", 4'b0000, 4'b0000, 8'h0);
        done4 = '0; outp4 = '0;

        // Round-robin contention on outport 0: order 0, 1, 3, 0.
        req4 = 4'b1011;
        step("rr_g0", 4'b0001, 4'b0001, s4(0, 0));
        step("rr_h0a", 4'b0000, 4'b0001, s4(0, 0));
        req4 = 4'b1010;
        step("rr_h0b", 4'b0000, 4'b0001, s4(0, 0));
        step("rr_h0c", 4'b0000, 4'b0001, s4(0, 0));
        done4 = 4'b0001;
        step("rr_g1", 4'b0010, 4'b0001, s4(0, 1));
        done4 = '0;
        step("rr_h1a", 4'b0000, 4'b0001, s4(0, 1));
        req4 = 4'b1000;
        step("rr_h1b", 4'b0000, 4'b0001, s4(0, 1));
        step("rr_h1c", 4'b0000, 4'b0001, s4(0, 1));
        done4 = 4'b0010;
        step("rr_g3", 4'b1000, 4'b0001, s4(0, 3));
        done4 = '0; req4 = 4'b1001;
        step("rr_h3a", 4'b0000, 4'b0001, s4(0, 3));
        req4 = 4'b0001;
        step("rr_h3b", 4'b0000, 4'b0001, s4(0, 3));
        step("rr_h3c", 4'b0000, 4'b0001, s4(0, 3));
        done4 = 4'b1000;
        step("rr_g0b", 4'b0001, 4'b0001, s4(0, 0));
        done4 = '0;
        step("rr_h0d", 4'b0000, 4'b0001, s4(0, 0));
        req4 = '0;
        step("rr_h0e", 4'b0000, 4'b0001, s4(0, 0));
        done4 = 4'b0001;
        step("rr_rel", 4'b0000, 4'b0000, 8'h0);
        done4 = '0;

        // Parallel outports.
        req4 = 4'b0011; outp4[0] = 2'd2; outp4[1] = 2'd3;
        step("par_g", 4'b0011, 4'b1100, s4(2, 0) | s4(3, 1));
        req4 = '0;
        step("par_h", 4'b0000, 4'b1100, s4(2, 0) | s4(3, 1));
        done4 = 4'b0011;
        step("par_rel", 4'b0000, 4'b0000, 8'h0);
        done4 = '0; outp4 = '0;

        // Stray pkt_done from a non-owner is ignored.
        req4 = 4'b0010;
        step("stray_g", 4'b0010, 4'b0001, s4(0, 1));
        req4 = '0; done4 = 4'b1000;
        step("stray_ign", 4'b0000, 4'b0001, s4(0, 1));
        done4 = '0;
        step("stray_h", 4'b0000, 4'b0001, s4(0, 1));

        // Asynchronous reset mid-packet.
        nRST = 1'b0;
        #1;
        push4("async_rst", 4'b0, 4'b0, 8'h0);
        check_now();
        @(negedge CLK);
        step("rst_mid_hold", 4'b0000, 4'b0000, 8'h0);
        nRST = 1'b1; req4 = 4'b1000;
        step("rereq_g", 4'b1000, 4'b0001, s4(0, 3));
        req4 = '0;
        step("rereq_h", 4'b0000, 4'b0001, s4(0, 3));

        // New request in the same cycle as the owner's pkt_done.
        done4 = 4'b1000; req4 = 4'b0100;
        step("samecyc_g", 4'b0100, 4'b0001, s4(0, 2));
        done4 = '0; req4 = '0;
        step("samecyc_h", 4'b0000, 4'b0001, s4(0, 2));
        done4 = 4'b0100;
        step("samecyc_rel", 4'b0000, 4'b0000, 8'h0);
        done4 = '0;

        // Three buffers contending for outport 0 of the 3-buffer instance.
        req3 = 3'b111;
        step3("nb3_g0", 3'b001, 2'b01, 4'h0);
        step3("nb3_h0", 3'b000, 2'b01, 4'h0);
        done3 = 3'b001;
        step3("nb3_g1", 3'b010, 2'b01, 4'h1);
        done3 = '0;
        step3("nb3_h1", 3'b000, 2'b01, 4'h1);
        done3 = 3'b010;
        step3("nb3_g2", 3'b100, 2'b01, 4'h2);
        done3 = '0;
        step3("nb3_h2", 3'b000, 2'b01, 4'h2);
        done3 = 3'b100;
        step3("nb3_g0b", 3'b001, 2'b01, 4'h0);
        done3 = '0; req3 = '0;
        step3("nb3_h0b", 3'b000, 2'b01, 4'h0);
        done3 = 3'b001;
        step3("nb3_rel", 3'b000, 2'b00, 4'h0);
        done3 = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-outport round-robin switch allocator for the chiplet switch. It sits directly downstream of the input-buffer stage. It consumes each buffer's switch request and requested outport, and returns a one-cycle switch grant that moves the buffer from SWITCH_ALLOCATION to ACTIVE. It then reserves the outport for the whole packet and drives the crossbar select for that outport until the buffer reports that the tail flit has been read.

## Interface
- NUM_BUFFERS, default 4: number of input buffers (requesters); any value ≥ 2.
- NUM_OUTPORTS, default 4: number of switch outports; any value ≥ 2.
- SELW = $clog2(NUM_BUFFERS); OPW = $clog2(NUM_OUTPORTS): derived localparams, not overridable.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  switch clock; all state changes on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_switch  in  [NUM_BUFFERS]  buffer i is in SWITCH_ALLOCATION and requests an outport.
- switch_outport  in  [NUM_BUFFERS][OPW]  outport requested by buffer i; only meaningful while req_switch[i]=1.
- pkt_done  in  [NUM_BUFFERS]  one-cycle pulse: buffer i read its last flit (ACTIVE→IDLE).
- switch_granted  out  [NUM_BUFFERS]  registered one-cycle grant pulse to buffer i.
- outport_busy  out  [NUM_OUTPORTS]  outport o is reserved by a packet; doubles as crossbar enable.
- xbar_sel  out  [NUM_OUTPORTS][SELW]  index of the buffer owning outport o; 0 when not busy.

## Operation
- Per-outport state: busy bit, owner[SELW], rr_ptr[SELW]. Outports arbitrate independently and in parallel.
- Candidates for outport o: every i with req_switch[i]=1, switch_outport[i]==o and switch_granted[i]=0. The grant-pulse cycle is excluded because the buffer still shows SWITCH_ALLOCATION during it.
- Outport o is "free this cycle" when busy=0, or when busy=1 and pkt_done[owner]=1.
- If o is free this cycle and has at least one candidate:
  - winner = first candidate scanning i = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_BUFFERS. Wrap is explicit for non-power-of-2 counts.
  - Next edge: busy←1, owner←winner, rr_ptr←(winner+1) mod NUM_BUFFERS, switch_granted[winner]←1.
- If o is free this cycle and has no candidate: busy←0 and owner←0. If busy was already 0, nothing changes.
- pkt_done[i] acts only on the outport with busy=1 and owner==i. pkt_done from a non-owner, or to an idle outport, is ignored and changes no state.
- A buffer requests exactly one outport, so it wins at most one outport per cycle. switch_granted is the OR over outports of their registered grants.
- switch_granted is cleared to 0 on every edge that produces no new grant, so it is never high for two consecutive cycles to the same buffer.
- Outputs are registered directly from state: outport_busy = busy; xbar_sel = owner (owner is 0 when idle).

## Timing
- Reset (async assert): busy=0, owner=0, rr_ptr=0 for all outports; switch_granted=0, outport_busy=0, xbar_sel=0. Reset takes effect immediately, including mid-packet. The first arbitration occurs at the first rising edge after nRST deasserts.
- Grant latency: request visible in cycle N on a free outport → switch_granted and outport_busy high in cycle N+1. xbar_sel is valid from N+1.
- Back-to-back packets: pkt_done from the owner in cycle N with another candidate waiting → new owner in N+1. outport_busy stays 1 with no bubble; xbar_sel changes at that edge.
- pkt_done with no waiting candidate: outport_busy drops in cycle N+1.
- A request that arrives in the same cycle as pkt_done is arbitrated with the others in that cycle.
- Fairness: with every buffer requesting continuously, a given buffer waits at most NUM_BUFFERS−1 packets per outport.

## Test plan
- Reset: hold nRST=0 with random inputs → all outputs 0. Deassert with no requests → outputs stay 0.
- Single grant: req_switch=4'b0100, switch_outport[2]=1 in cycle N → switch_granted=4'b0100 only in N+1; outport_busy=4'b0010 from N+1; xbar_sel[1]=2. Pulse pkt_done[2] in cycle M → outport_busy[1]=0 and xbar_sel[1]=0 in M+1.
- Round-robin contention: buffers 0, 1, 3 hold requests to outport 0, and each owner pulses pkt_done 3 cycles after its grant → grant order 0, 1, 3, 0. outport_busy[0] stays continuously 1 and each grant appears the cycle after the previous pkt_done.
- Parallel outports: buffer 0→outport 2 and buffer 1→outport 3 requested in the same cycle → switch_granted=4'b0011 in the next cycle; xbar_sel[2]=0, xbar_sel[3]=1.
- Stray pkt_done: buffer 1 owns outport 0; pulse pkt_done[3] → no change. Also assert nRST while outport 0 is busy → all state 0 immediately; a re-request after reset is granted normally.
- Non-power-of-2: NUM_BUFFERS=3, all requesting outport 0 → grant order 0, 1, 2, 0; rr_ptr never holds 3.
